// File: rtl/repetition_scrubbed_register.sv
// Word stored as REPETITION copies with per-bit majority vote on read and a
// periodic scrub FSM that re-votes the copies and writes the corrected word back.
module repetition_scrubbed_register #(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           REPETITION    = 3,
    parameter int unsigned           SCRUB_PERIOD  = 256,
    parameter int unsigned           COUNTER_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                write_enable,
    input  logic [DATA_WIDTH-1:0]               write_data,
    input  logic                                read_enable,
    output logic                                read_valid,
    output logic [DATA_WIDTH-1:0]               read_data,
    output logic                                read_error,
    output logic                                read_uncorrectable,
    input  logic                                inject_enable,
    input  logic [$clog2(REPETITION)-1:0]       inject_copy_index,
    input  logic [DATA_WIDTH-1:0]               inject_mask,
    output logic                                scrub_active,
    output logic [COUNTER_WIDTH-1:0]            error_count,
    input  logic                                error_count_clear,
    output logic                                uncorrectable_flag
);

    localparam int unsigned TMR_W = $clog2(SCRUB_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK
    } state_e;

    state_e                   state_q, state_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0]    copies_q [REPETITION];
    logic [DATA_WIDTH-1:0]    copies_d [REPETITION];
    logic [DATA_WIDTH-1:0]    scrub_vote_q, scrub_vote_d;
    logic                     read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
    logic                     read_error_q, read_error_d;
    logic                     read_unc_q, read_unc_d;
    logic [COUNTER_WIDTH-1:0] error_count_q, error_count_d;
    logic                     unc_flag_q, unc_flag_d;

    logic [DATA_WIDTH-1:0]    voted;
    logic [DATA_WIDTH-1:0]    bit_err;
    logic [DATA_WIDTH-1:0]    bit_tie;
    logic                     do_writeback;

    // Per-bit vote; a tie (even REPETITION only) falls back to copy 0.
    always_comb begin
        int unsigned ones;
        voted   = '0;
        bit_err = '0;
        bit_tie = '0;
        ones    = 0;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            ones = 0;
            for (int unsigned c = 0; c < REPETITION; c++) begin
                ones += 32'(copies_q[c][b]);
            end
            bit_err[b] = (ones != 0) && (ones != REPETITION);
            bit_tie[b] = ((2 * ones) == REPETITION);
            voted[b]   = bit_tie[b] ? copies_q[0][b] : (ones > (REPETITION / 2));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            for (int unsigned c = 0; c < REPETITION; c++) begin
                copies_q[c] <= RESET_VALUE;
            end
            scrub_vote_q  <= '0;
            read_valid_q  <= 1'b0;
            read_data_q   <= '0;
            read_error_q  <= 1'b0;
            read_unc_q    <= 1'b0;
            error_count_q <= '0;
            unc_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            copies_q      <= copies_d;
            scrub_vote_q  <= scrub_vote_d;
            read_valid_q  <= read_valid_d;
            read_data_q   <= read_data_d;
            read_error_q  <= read_error_d;
            read_unc_q    <= read_unc_d;
            error_count_q <= error_count_d;
            unc_flag_q    <= unc_flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (timer_q == TMR_W'(SCRUB_PERIOD - 1)) begin
                    state_d = CHECK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (write_enable || !(|bit_err) || (|bit_tie)) state_d = IDLE;
                else                                            state_d = WRITEBACK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_writeback = (state_q == WRITEBACK) && !write_enable;
        copies_d     = copies_q;
        if (write_enable) begin
            for (int unsigned c = 0; c < REPETITION; c++) copies_d[c] = write_data;
        end else if (do_writeback) begin
            for (int unsigned c = 0; c < REPETITION; c++) copies_d[c] = scrub_vote_q;
        end else if (inject_enable && (32'(inject_copy_index) < REPETITION)) begin
            copies_d[inject_copy_index] = copies_q[inject_copy_index] ^ inject_mask;
        end

        scrub_vote_d = (state_q == CHECK) ? voted : scrub_vote_q;

        read_valid_d = read_enable;
        read_data_d  = read_enable ? voted     : read_data_q;
        read_error_d = read_enable ? |bit_err  : read_error_q;
        read_unc_d   = read_enable ? |bit_tie  : read_unc_q;

        if (error_count_clear)                       error_count_d = '0;
        else if (do_writeback && (error_count_q != '1)) error_count_d = error_count_q + 1'b1;
        else                                         error_count_d = error_count_q;

        if (write_enable)                             unc_flag_d = 1'b0;
        else if ((state_q == CHECK) && (|bit_tie))    unc_flag_d = 1'b1;
        else                                          unc_flag_d = unc_flag_q;

        scrub_active = (state_q != IDLE);
    end

    assign read_valid         = read_valid_q;
    assign read_data          = read_data_q;
    assign read_error         = read_error_q;
    assign read_uncorrectable = read_unc_q;
    assign error_count        = error_count_q;
    assign uncorrectable_flag = unc_flag_q;

endmodule
